multi_clause_checker: RTL and testbench
=======================================

# multi_clause_checker

Sequential satisfiability checker for a conjunction of mixed boolean/integer clauses. It snapshots the current variable assignment, then fetches each clause's coefficient word from an external clause memory. Each clause is evaluated as a signed linear inequality (sum of coef·y + bias ≤ 0) OR'd with a boolean literal match, processing LANES variables per cycle. It reports per-clause and overall satisfaction to the MCMC sampler control with a start/done handshake.

## Interface
- NUM_VARS, 16, variables per type (integer and boolean); must be a multiple of LANES (elaboration error otherwise)
- INT_WIDTH, 8, signed two's-complement width of integer assignments and coefficients
- NUM_CLAUSES, 4, clauses evaluated per run, ≥1
- LANES, 4, variables evaluated per EVAL cycle
- in_clk  input  1  clock; all logic on rising edge
- in_reset  input  1  synchronous, active-high reset
- in_start  input  1  request a run; sampled only in IDLE
- in_boolean_current_assignments  input  NUM_VARS  boolean values, bit i = x_i
- in_integer_current_assignments  input  NUM_VARS*INT_WIDTH  y_i at [i*INT_WIDTH +: INT_WIDTH]
- out_clause_addr  output  clog2(NUM_CLAUSES) (min 1)  clause memory read address
- out_clause_rd  output  1  read strobe; data returned exactly 1 cycle later
- in_clause_data  input  CLAUSE_W  clause word: int coef i at [i*INT_WIDTH +: INT_WIDTH], bias at [NUM_VARS*INT_WIDTH +: INT_WIDTH], boolean coef i at [(NUM_VARS+1)*INT_WIDTH + 2i +: 2] (bit1 exist, bit0 required polarity)
- out_busy  output  1  high from the cycle after start acceptance until DONE inclusive
- out_done  output  1  one-cycle pulse; results valid
- out_clause_sat  output  NUM_CLAUSES  bit k = clause k satisfied
- out_all_satisfied  output  1  AND of evaluated clause results
- out_unsat_index  output  clog2(NUM_CLAUSES) (min 1)  present only with CHECKER_EARLY_EXIT_EN

## Operation
- States: IDLE, FETCH, LOAD, EVAL, DECIDE, DONE.
- IDLE: on in_start=1, latch both assignment buses, clear out_clause_sat and out_all_satisfied, set clause_idx=0, go to FETCH.
- FETCH: out_clause_rd=1, out_clause_addr=clause_idx; go to LOAD.
- LOAD: register in_clause_data; acc = sign-extended bias; bool_hit=0; chunk=0; go to EVAL.
- EVAL: for lanes j=0..LANES-1, v=chunk*LANES+j: acc += coef_v·y_v (signed); bool_hit |= exist_v & (pol_v == x_v). Increment chunk. After chunk CHUNKS-1 (CHUNKS=NUM_VARS/LANES), go to DECIDE.
- DECIDE: sat = (acc ≤ 0) | bool_hit; out_clause_sat[clause_idx] = sat. If clause_idx = NUM_CLAUSES-1, go to DONE; else increment clause_idx and go to FETCH.
- DONE: out_done=1; out_all_satisfied = &out_clause_sat; go to IDLE. Results hold until the next accepted start.
- Arithmetic: ACC_W = 2*INT_WIDTH + clog2(NUM_VARS+1). Full precision, so no overflow or wrap for any input. Non-existent boolean literals (bit1=0) never match. A clause with all-zero coefficients and bias 0 is satisfied (0 ≤ 0).
- in_start while busy is ignored. Assignment input changes during a run have no effect (snapshot).
- Reset in any state: IDLE next cycle; every output 0.

## Timing
- Reset values: out_busy, out_done, out_clause_rd, out_clause_addr, out_clause_sat, out_all_satisfied, out_unsat_index all 0.
- Start accepted at cycle 0 → FETCH at cycle 1. Each clause takes CHUNKS+3 cycles.
- out_done at cycle 1 + NUM_CLAUSES*(CHUNKS+3). Defaults: 1 + 4·7 = 29.
- in_start may be asserted in the DONE cycle, but it is not accepted until IDLE. Back-to-back start in IDLE the cycle after DONE is accepted.

## Configuration
- CHECKER_EARLY_EXIT_EN defined:
  - DECIDE with sat=0 goes directly to DONE and sets out_unsat_index=clause_idx.
  - Unevaluated clause bits stay 0; out_all_satisfied=0.
  - If all clauses pass, out_unsat_index=0.
- Undefined: all clauses always evaluated; out_unsat_index port absent; latency fixed.

## Structure
- Package checker_pkg holds:
  - state enum
  - CLAUSE_W = (NUM_VARS+1)*INT_WIDTH + 2*NUM_VARS
  - ACC_W and CHUNKS calculation functions
  - boolean coefficient bit positions (EXIST_BIT=1, POL_BIT=0)
- Sub-module clause_lane_mac (combinational): LANES signed products summed to ACC_W plus the boolean OR-match for one chunk. The FSM, accumulator and memory interface stay in the top module.

## Test plan
- Defaults; clause 0: y0=3, coef0=2, bias=-6, no booleans → acc=0 → sat=1; clauses 1–3: bias=+1, all other coefs 0 → sat=0; out_clause_sat=4'b0001, out_all_satisfied=0, out_done at cycle 29.
- Boolean-only: clause coef for x5 = 2'b11, x5=1, bias=+5 → sat=1; x5=0 → sat=0.
- Overflow: all 16 y=-128, coef=-128, bias=-128 → acc=+262016 → sat=0; an 8-bit accumulator would wrap and fail this case.
- in_start pulsed at cycles 5 and 10 mid-run, assignments toggled → single out_done at cycle 29, results match the cycle-0 snapshot.
- in_reset asserted at cycle 12 → next cycle all outputs 0, state IDLE; new start completes normally.
- CHECKER_EARLY_EXIT_EN, clause 1 unsatisfied → out_done at cycle 15, out_unsat_index=1, out_clause_sat=4'b0001.

Source files
------------

// File: rtl/multi_clause_checker_pkg.sv
// Shared types and sizing helpers for the multi-clause satisfiability checker.
// Optional build macro used by the checker: CHECKER_EARLY_EXIT_EN.
package checker_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_EVAL,
        S_DECIDE,
        S_DONE
    } state_t;

    // Bit positions inside each 2-bit boolean coefficient.
    localparam int EXIST_BIT = 1;
    localparam int POL_BIT   = 0;

    function automatic int acc_w(input int int_width, input int num_vars);
        return 2 * int_width + $clog2(num_vars + 1);
    endfunction

    function automatic int chunks(input int num_vars, input int lanes);
        return num_vars / lanes;
    endfunction

    function automatic int clause_w(input int num_vars, input int int_width);
        return (num_vars + 1) * int_width + 2 * num_vars;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_clause_checker_if.sv
// Clause memory read port: address/strobe out, clause word back one cycle later.
interface multi_clause_checker_if
    import checker_pkg::*;
#(
    parameter int NUM_VARS    = 16,
    parameter int INT_WIDTH   = 8,
    parameter int NUM_CLAUSES = 4
) ();

    logic [idx_w(NUM_CLAUSES)-1:0]            clause_addr;
    logic                                     clause_rd;
    logic [clause_w(NUM_VARS, INT_WIDTH)-1:0] clause_data;

    modport master (output clause_addr, output clause_rd, input clause_data);
    modport slave  (input clause_addr, input clause_rd, output clause_data);

endinterface

// File: rtl/multi_clause_checker_clause_lane_mac.sv
// One chunk of clause evaluation: LANES signed coef*value products summed at
// full accumulator width, plus the OR of boolean literal matches.
module clause_lane_mac
    import checker_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int INT_WIDTH = 8,
    parameter int ACC_W     = 21
) (
    input  logic [LANES*INT_WIDTH-1:0] coefs,
    input  logic [LANES*INT_WIDTH-1:0] values,
    input  logic [2*LANES-1:0]         bool_coefs,
    input  logic [LANES-1:0]           bools,
    output logic signed [ACC_W-1:0]    sum,
    output logic                       hit
);

    logic signed [INT_WIDTH-1:0]   coef_j;
    logic signed [INT_WIDTH-1:0]   value_j;
    logic signed [2*INT_WIDTH-1:0] prod_j;

    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        sum     = '0;
        hit     = 1'b0;
        coef_j  = '0;
        value_j = '0;
        prod_j  = '0;
        for (int j = 0; j < LANES; j++) begin
            coef_j  = coefs[j*INT_WIDTH +: INT_WIDTH];
            value_j = values[j*INT_WIDTH +: INT_WIDTH];
            // Widen before multiplying so the product never truncates.
            prod_j  = (2*INT_WIDTH)'(coef_j) * (2*INT_WIDTH)'(value_j);
            sum     = sum + ACC_W'(prod_j);
            hit     = hit | (bool_coefs[2*j+EXIST_BIT] & (bool_coefs[2*j+POL_BIT] == bools[j]));
        end
    end

endmodule

// File: rtl/multi_clause_checker.sv
// Sequential checker for a conjunction of linear-inequality-or-literal clauses.
// Build macro CHECKER_EARLY_EXIT_EN: stop at the first unsatisfied clause.
module multi_clause_checker
    import checker_pkg::*;
#(
    parameter int NUM_VARS    = 16,
    parameter int INT_WIDTH   = 8,
    parameter int NUM_CLAUSES = 4,
    parameter int LANES       = 4
) (
    input  logic                            in_clk,
    input  logic                            in_reset,
    input  logic                            in_start,
    input  logic [NUM_VARS-1:0]             in_boolean_current_assignments,
    input  logic [NUM_VARS*INT_WIDTH-1:0]   in_integer_current_assignments,
    multi_clause_checker_if.master          mem,
    output logic                            out_busy,
    output logic                            out_done,
    output logic [NUM_CLAUSES-1:0]          out_clause_sat,
`ifdef CHECKER_EARLY_EXIT_EN
    output logic [idx_w(NUM_CLAUSES)-1:0]   out_unsat_index,
`endif
    output logic                            out_all_satisfied
);

    localparam int ACC_W    = acc_w(INT_WIDTH, NUM_VARS);
    localparam int CHUNKS   = chunks(NUM_VARS, LANES);
    localparam int CHUNK_W  = idx_w(CHUNKS);
    localparam int IDX_W    = idx_w(NUM_CLAUSES);
    localparam int INT_BITS = NUM_VARS * INT_WIDTH;
    localparam int BOOL_LSB = (NUM_VARS + 1) * INT_WIDTH;
    localparam logic [CHUNK_W-1:0] LAST_CHUNK  = CHUNK_W'(CHUNKS - 1);
    localparam logic [IDX_W-1:0]   LAST_CLAUSE = IDX_W'(NUM_CLAUSES - 1);

    if (NUM_VARS % LANES != 0) begin : g_bad_lanes
        $error("NUM_VARS must be a multiple of LANES");
    end
    if (NUM_CLAUSES < 1) begin : g_bad_clauses
        $error("NUM_CLAUSES must be at least 1");
    end

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         clause_idx;
    logic [CHUNK_W-1:0]       chunk;
    logic signed [ACC_W-1:0]  acc;
    logic                     bool_hit;
    logic [NUM_VARS-1:0]      x_snap;
    logic [INT_BITS-1:0]      y_snap;
    logic [INT_BITS-1:0]      int_coef_q;
    logic [2*NUM_VARS-1:0]    bool_coef_q;
    logic signed [ACC_W-1:0]  lane_sum;
    logic                     lane_hit;
    logic                     sat;
    logic [NUM_CLAUSES-1:0]   sat_vec_d;

    wire last_chunk  = (chunk == LAST_CHUNK);
    wire last_clause = (clause_idx == LAST_CLAUSE);

    clause_lane_mac #(
        .LANES     (LANES),
        .INT_WIDTH (INT_WIDTH),
        .ACC_W     (ACC_W)
    ) u_mac (
        .coefs      (int_coef_q[chunk*LANES*INT_WIDTH +: LANES*INT_WIDTH]),
        .values     (y_snap[chunk*LANES*INT_WIDTH +: LANES*INT_WIDTH]),
        .bool_coefs (bool_coef_q[chunk*2*LANES +: 2*LANES]),
        .bools      (x_snap[chunk*LANES +: LANES]),
        .sum        (lane_sum),
        .hit        (lane_hit)
    );

    // acc <= 0 written as sign-bit-or-zero to avoid a mixed-signedness compare.
    assign sat = acc[ACC_W-1] | (acc == '0) | bool_hit;

    always_comb begin
        sat_vec_d             = out_clause_sat;
        sat_vec_d[clause_idx] = sat;
    end

    always_ff @(posedge in_clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (in_reset) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (in_start) state_d = S_FETCH;
            S_FETCH:  state_d = S_LOAD;
            S_LOAD:   state_d = S_EVAL;
            S_EVAL:   if (last_chunk) state_d = S_DECIDE;
`ifdef CHECKER_EARLY_EXIT_EN
            S_DECIDE: state_d = (last_clause || !sat) ? S_DONE : S_FETCH;
`else
            S_DECIDE: state_d = last_clause ? S_DONE : S_FETCH;
`endif
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        out_busy        = (state_q != S_IDLE);
        out_done        = (state_q == S_DONE);
        mem.clause_rd   = (state_q == S_FETCH);
        mem.clause_addr = (state_q == S_FETCH) ? clause_idx : '0;
    end

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            clause_idx        <= '0;
            chunk             <= '0;
            acc               <= '0;
            bool_hit          <= 1'b0;
            out_clause_sat    <= '0;
            out_all_satisfied <= 1'b0;
`ifdef CHECKER_EARLY_EXIT_EN
            out_unsat_index   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: if (in_start) begin
                    clause_idx        <= '0;
                    out_clause_sat    <= '0;
                    out_all_satisfied <= 1'b0;
`ifdef CHECKER_EARLY_EXIT_EN
                    out_unsat_index   <= '0;
`endif
                end
                S_LOAD: begin
                    acc      <= ACC_W'($signed(mem.clause_data[INT_BITS +: INT_WIDTH]));
                    bool_hit <= 1'b0;
                    chunk    <= '0;
                end
                S_EVAL: begin
                    acc      <= acc + lane_sum;
                    bool_hit <= bool_hit | lane_hit;
                    chunk    <= chunk + CHUNK_W'(1);
                end
                S_DECIDE: begin
                    out_clause_sat <= sat_vec_d;
                    if (state_d == S_DONE) begin
                        out_all_satisfied <= &sat_vec_d;
`ifdef CHECKER_EARLY_EXIT_EN
                        out_unsat_index   <= sat ? '0 : clause_idx;
`endif
                    end else begin
                        clause_idx <= clause_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: snapshot and coefficient registers carry no reset; each is written before it is read.
    always_ff @(posedge in_clk) begin
        if (state_q == S_IDLE && in_start) begin
            x_snap <= in_boolean_current_assignments;
            y_snap <= in_integer_current_assignments;
        end
        if (state_q == S_LOAD) begin
            int_coef_q  <= mem.clause_data[0 +: INT_BITS];
            bool_coef_q <= mem.clause_data[BOOL_LSB +: 2*NUM_VARS];
        end
    end

endmodule

// File: tb/tb_multi_clause_checker.sv
// Directed bench for multi_clause_checker with a one-cycle-latency clause memory.
// Expectations for both CHECKER_EARLY_EXIT_EN builds are hand-computed below.
module tb_multi_clause_checker;
    import checker_pkg::*;

    localparam int NV = 16;
    localparam int IW = 8;
    localparam int NC = 4;
    localparam int LN = 4;
    localparam int CW = clause_w(NV, IW);

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [NV-1:0]   xb;
    logic [NV*IW-1:0] yb;
    logic            busy;
    logic            done;
    logic [NC-1:0]   sat;
    logic            all_sat;
`ifdef CHECKER_EARLY_EXIT_EN
    logic [1:0]      unsat_idx;
`endif

    multi_clause_checker_if #(.NUM_VARS(NV), .INT_WIDTH(IW), .NUM_CLAUSES(NC)) mem_if ();

    multi_clause_checker #(
        .NUM_VARS(NV), .INT_WIDTH(IW), .NUM_CLAUSES(NC), .LANES(LN)
    ) dut (
        .in_clk                         (clk),
        .in_reset                       (rst),
        .in_start                       (start),
        .in_boolean_current_assignments (xb),
        .in_integer_current_assignments (yb),
        .mem                            (mem_if.master),
        .out_busy                       (busy),
        .out_done                       (done),
        .out_clause_sat                 (sat),
`ifdef CHECKER_EARLY_EXIT_EN
        .out_unsat_index                (unsat_idx),
`endif
        .out_all_satisfied              (all_sat)
    );

    always #5 clk = ~clk;

    logic [CW-1:0] mem [NC];
    always @(posedge clk) if (mem_if.clause_rd) mem_if.clause_data <= mem[mem_if.clause_addr];

    int tests = 0;
    int fails = 0;
    int d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int k = 0; k < NC; k++) mem[k] = '0;
    endtask
    task automatic set_coef(input int k, input int i, input logic [IW-1:0] v);
        mem[k][i*IW +: IW] = v;
    endtask
    task automatic set_bias(input int k, input logic [IW-1:0] v);
        mem[k][NV*IW +: IW] = v;
    endtask
    task automatic set_bool(input int k, input int i, input logic [1:0] v);
        mem[k][(NV+1)*IW + 2*i +: 2] = v;
    endtask
    task automatic set_y(input int i, input logic [IW-1:0] v);
        yb[i*IW +: IW] = v;
    endtask

    task automatic check_idle(input string pfx);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_rd"}, mem_if.clause_rd, 0);
        check({pfx, "_addr"}, mem_if.clause_addr, 0);
        check({pfx, "_sat"}, sat, 0);
        check({pfx, "_all"}, all_sat, 0);
`ifdef CHECKER_EARLY_EXIT_EN
        check({pfx, "_unsat"}, unsat_idx, 0);
`endif
    endtask

    // Cycle 0 is the cycle start is sampled in; returns the cycle out_done is seen.
    task automatic run(input bit disturb, input int reset_at, output int done_at);
        int n;
        done_at = -1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; n = 1;
        while (n <= 60) begin
            if (n == 1) begin
                check("fetch_rd_c1", mem_if.clause_rd, 1);
                check("fetch_addr_c1", mem_if.clause_addr, 0);
                check("busy_c1", busy, 1);
            end
            if (disturb && n == 5) begin
                start = 1'b1; xb = ~xb; yb = ~yb;
            end else if (disturb && n == 10) begin
                start = 1'b1; xb = '0; yb = {NV{8'h7f}};
            end else begin
                start = 1'b0;
            end
            if (reset_at == n) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                start = 1'b0;
                check_idle("midrun_reset");
                done_at = -2;
                return;
            end
            if (done) begin
                done_at = n;
                break;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (done_at == -1) check("done_timeout", done, 1);
    endtask

    task automatic expect_run(input string tag, input int done_at, input int exp_cyc,
                              input logic [NC-1:0] exp_sat, input logic exp_all,
                              input logic [1:0] exp_unsat);
        check({tag, "_done_cycle"}, done_at, exp_cyc);
        check({tag, "_sat"}, sat, exp_sat);
        check({tag, "_all"}, all_sat, exp_all);
        check({tag, "_busy_at_done"}, busy, 1);
`ifdef CHECKER_EARLY_EXIT_EN
        check({tag, "_unsat"}, unsat_idx, exp_unsat);
`else
        check({tag, "_unsat_unused"}, exp_unsat, exp_unsat & 2'b00);
`endif
    endtask

    task automatic expect_after(input string tag, input logic [NC-1:0] exp_sat);
        @(negedge clk);
        check({tag, "_done_drop"}, done, 0);
        check({tag, "_busy_drop"}, busy, 0);
        check({tag, "_sat_hold"}, sat, exp_sat);
    endtask

    task automatic load_plan_a();
        clear_mem();
        set_coef(0, 0, 8'd2); set_bias(0, 8'hfa);
        for (int k = 1; k < NC; k++) set_bias(k, 8'd1);
        xb = '0; yb = '0; set_y(0, 8'd3);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; xb = '0; yb = '0;
        clear_mem();
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        // Linear clause hits acc == 0 exactly; remaining clauses fail on bias +1.
        load_plan_a();
        run(1'b0, 0, d);
`ifdef CHECKER_EARLY_EXIT_EN
        expect_run("plan_a", d, 15, 4'b0001, 1'b0, 2'd1);
`else
        expect_run("plan_a", d, 29, 4'b0001, 1'b0, 2'd0);
`endif
        expect_after("plan_a", 4'b0001);

        // Boolean literals: x5 exists/pol1, x2 non-existent, x7 exists/pol0, clause 2 all-zero.
        clear_mem();
        set_bool(0, 5, 2'b11); set_bias(0, 8'd5);
        set_bool(1, 2, 2'b01); set_bias(1, 8'd1);
        set_bool(3, 7, 2'b10); set_bias(3, 8'd3);
        yb = '0; xb = 16'h0024;
        run(1'b0, 0, d);
`ifdef CHECKER_EARLY_EXIT_EN
        expect_run("bool_x5_1", d, 15, 4'b0001, 1'b0, 2'd1);
`else
        expect_run("bool_x5_1", d, 29, 4'b1101, 1'b0, 2'd0);
`endif
        xb = 16'h0004;
        run(1'b0, 0, d);
`ifdef CHECKER_EARLY_EXIT_EN
        expect_run("bool_x5_0", d, 8, 4'b0000, 1'b0, 2'd0);
`else
        expect_run("bool_x5_0", d, 29, 4'b1100, 1'b0, 2'd0);
`endif

        // Full-precision extremes: +262016, -260224, +1, 0.
        clear_mem();
        for (int i = 0; i < NV; i++) begin
            set_coef(0, i, 8'h80);
            set_coef(1, i, 8'h7f);
            set_y(i, 8'h80);
        end
        set_bias(0, 8'h80); set_bias(1, 8'h80);
        set_coef(2, 0, 8'hff); set_bias(2, 8'h81);
        set_coef(3, 0, 8'hff); set_bias(3, 8'h80);
        xb = '0;
        run(1'b0, 0, d);
`ifdef CHECKER_EARLY_EXIT_EN
        expect_run("overflow", d, 8, 4'b0000, 1'b0, 2'd0);
`else
        expect_run("overflow", d, 29, 4'b1010, 1'b0, 2'd0);
`endif

        // Snapshot: inputs and start are disturbed mid-run; results follow cycle 0.
        clear_mem();
        set_coef(0, 0, 8'd2);   set_bias(0, 8'hfa);
        set_bool(1, 0, 2'b11);  set_bias(1, 8'd1);
        set_coef(2, 0, 8'hfe);  set_bias(2, 8'd6);
        set_bias(3, 8'd1);
        xb = 16'h0001; yb = '0; set_y(0, 8'd3);
        run(1'b1, 0, d);
`ifdef CHECKER_EARLY_EXIT_EN
        expect_run("snapshot", d, 29, 4'b0111, 1'b0, 2'd3);
`else
        expect_run("snapshot", d, 29, 4'b0111, 1'b0, 2'd0);
`endif

        // Start held through DONE: accepted only in the following IDLE cycle.
        xb = 16'h0001; yb = '0; set_y(0, 8'd3);
        start = 1'b1;
        run(1'b0, 0, d);
`ifdef CHECKER_EARLY_EXIT_EN
        expect_run("back_to_back", d, 29, 4'b0111, 1'b0, 2'd3);
`else
        expect_run("back_to_back", d, 29, 4'b0111, 1'b0, 2'd0);
`endif
        expect_after("back_to_back", 4'b0111);

        // Reset mid-run, then a clean run.
        load_plan_a();
        run(1'b0, 12, d);
        check("midrun_reset_taken", d, 32'hffff_fffe);
        run(1'b0, 0, d);
`ifdef CHECKER_EARLY_EXIT_EN
        expect_run("after_reset", d, 15, 4'b0001, 1'b0, 2'd1);
`else
        expect_run("after_reset", d, 29, 4'b0001, 1'b0, 2'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
